// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared defaults, FSM encodings and helpers for the serial
//               word receiver (uart_rx_assemble / uart_rx_bit_sampler).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Default build parameters
    localparam int unsigned c_clk_div   = 16;            // clocks per bit
    localparam logic [31:0] c_sync_word = 32'hA5A5_5A5A; // alignment pattern
    localparam int unsigned c_idle_w    = 18;            // idle counter width

    // Alignment FSM encoding
    localparam logic [0:0] c_st_hunt   = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_bit_sampler
// Description : Bit-timing recovery for an unframed, MSB-first serial line.
//               2-flop synchronizer plus a third stage for edge detection,
//               a phase counter re-zeroed on every line transition, a mid-bit
//               sample strobe and a saturating idle counter.
//               Optional macro UART_RX_MAJORITY_EN: 3-sample majority vote
//               around mid-bit, strobe moved two phases later.
// Revision    : 1.0 - initial release
// Ports       : i_clk      - clock
//               i_rst      - asynchronous active-high reset
//               i_rxd      - raw serial line (asynchronous, idles high)
//               o_bit      - sampled bit, valid with o_strobe
//               o_strobe   - one-cycle sample strobe
//               o_idle_sat - idle counter saturated (no transition seen)
// ============================================================================
module uart_rx_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV = c_clk_div,
    parameter int unsigned IDLE_W  = c_idle_w
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rxd,
    output logic o_bit,
    output logic o_strobe,
    output logic o_idle_sat
);

    localparam int unsigned       c_ph_w    = $clog2(CLK_DIV);
    localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(CLK_DIV - 1);
    localparam logic [c_ph_w-1:0] c_ph_mid  = c_ph_w'(CLK_DIV / 2 - 1);

    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic [c_ph_w-1:0] r_phase;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              w_edge;
    logic              w_phase_clr;

    // Synchronizer stages reset to the idle level so reset release is not
    // mistaken for a line transition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_rxd;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 ^ r_s3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= '0;
        end else if (w_phase_clr || (r_phase == c_ph_last)) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_ph_w'(1);
        end
    end

    // Starts saturated so the line reads as inactive until it first toggles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idle_cnt <= '1;
        end else if (w_edge) begin
            r_idle_cnt <= '0;
        end else if (!(&r_idle_cnt)) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end

    assign o_idle_sat = &r_idle_cnt;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_ph_w-1:0] c_ph_v1  = c_ph_w'(CLK_DIV / 2);
    localparam logic [c_ph_w-1:0] c_ph_stb = c_ph_w'(CLK_DIV / 2 + 1);

    logic r_v0;
    logic r_v1;
    logic r_synced;
    logic w_in_window;

    // Once bit timing has been acquired, a transition inside the voting
    // window is a glitch, not a bit boundary: real boundaries land where the
    // phase wraps. Until the first accepted edge (or after a long idle) any
    // transition re-times the counter so acquisition cannot get stuck.
    assign w_in_window = (r_phase >= c_ph_mid) && (r_phase <= c_ph_stb);
    assign w_phase_clr = w_edge && !(r_synced && w_in_window);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v0     <= 1'b1;
            r_v1     <= 1'b1;
            r_synced <= 1'b0;
        end else begin
            if (r_phase == c_ph_mid) begin
                r_v0 <= r_s3;
            end
            if (r_phase == c_ph_v1) begin
                r_v1 <= r_s3;
            end
            if (w_phase_clr) begin
                r_synced <= 1'b1;
            end else if (o_idle_sat) begin
                r_synced <= 1'b0;
            end
        end
    end

    assign o_strobe = (r_phase == c_ph_stb);
    assign o_bit    = maj3(r_v0, r_v1, r_s3);
`else
    assign w_phase_clr = w_edge;
    assign o_strobe    = (r_phase == c_ph_mid);
    assign o_bit       = r_s3;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx_assemble.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_assemble
// Description : Receives a continuous stream of unframed 32-bit words,
//               aligns on SYNC_WORD and writes each following word into a
//               downstream FIFO (drop-and-flag when the FIFO is full).
//               Optional macro UART_RX_MAJORITY_EN selects 3-sample majority
//               bit recovery (write strobe 2 cycles later).
// Revision    : 1.0 - initial release
// Ports       : i_clk         - clock, rising edge
//               i_rst         - asynchronous active-high reset
//               i_uart_rxd    - serial line, idles high
//               i_fifo_full   - downstream FIFO full
//               o_data        - assembled word, valid with o_fifo_wr_en
//               o_fifo_wr_en  - one-cycle write strobe
//               o_locked      - aligned to the word stream
//               o_line_active - line has toggled within the idle window
//               o_overflow    - sticky: a word was dropped (FIFO full)
// ============================================================================
module uart_rx_assemble
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV   = c_clk_div,
    parameter logic [31:0] SYNC_WORD = c_sync_word,
    parameter int unsigned IDLE_W    = c_idle_w
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_uart_rxd,
    input  logic        i_fifo_full,
    output logic [31:0] o_data,
    output logic        o_fifo_wr_en,
    output logic        o_locked,
    output logic        o_line_active,
    output logic        o_overflow
);

    logic        w_bit;
    logic        w_strobe;
    logic        w_idle_sat;
    logic [31:0] w_shift_next;

    logic [0:0]  r_state;
    logic [31:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_data;
    logic        r_wr_en;
    logic        r_overflow;

    uart_rx_bit_sampler #(
        .CLK_DIV (CLK_DIV),
        .IDLE_W  (IDLE_W)
    ) u_sampler (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rxd      (i_uart_rxd),
        .o_bit      (w_bit),
        .o_strobe   (w_strobe),
        .o_idle_sat (w_idle_sat)
    );

    assign w_shift_next = {r_shift[30:0], w_bit};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= c_st_hunt;
            r_shift    <= '1;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_wr_en    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_strobe) begin
                r_shift <= w_shift_next;
            end
            case (r_state)
                c_st_hunt: begin
                    r_bit_cnt <= '0;
                    if (w_strobe && (w_shift_next == SYNC_WORD)) begin
                        r_state <= c_st_locked;
                    end
                end
                c_st_locked: begin
                    if (w_strobe) begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        // 32nd bit of the word: publish or drop it
                        if (r_bit_cnt == 5'd31) begin
                            if (!i_fifo_full) begin
                                r_data  <= w_shift_next;
                                r_wr_en <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end
                    // Loss of activity: abandon the partial word. A word
                    // completing in this same cycle is still written above.
                    if (w_idle_sat) begin
                        r_state   <= c_st_hunt;
                        r_bit_cnt <= '0;
                    end
                end
                default: begin
                    r_state   <= c_st_hunt;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    assign o_data        = r_data;
    assign o_fifo_wr_en  = r_wr_en;
    assign o_locked      = (r_state == c_st_locked);
    assign o_line_active = ~w_idle_sat;
    assign o_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_assemble.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_assemble
// Description : Directed self-checking bench for uart_rx_assemble. Words are
//               driven MSB first, 16 clocks per bit, each bit set 1 ns after
//               a rising edge. A word whose first bit is set after edge S has
//               its write strobe visible during cycle S + 507 (S + 509 with
//               UART_RX_MAJORITY_EN, where every bit also carries a one-cycle
//               glitch at mid-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_assemble;

    localparam int unsigned c_clk_div = 16;
    localparam int unsigned c_idle_w  = 10;
    localparam logic [31:0] c_sync    = 32'hA5A5_5A5A;
`ifdef UART_RX_MAJORITY_EN
    localparam int c_lat = 509;
`else
    localparam int c_lat = 507;
`endif

    logic        r_clk       = 1'b0;
    logic        r_rst       = 1'b0;
    logic        r_rxd       = 1'b1;
    logic        r_fifo_full = 1'b0;
    logic [31:0] w_data;
    logic        w_wr_en;
    logic        w_locked;
    logic        w_line_active;
    logic        w_overflow;

    int r_cyc      = 0;
    int r_wr_count = 0;
    int n_checks   = 0;
    int n_errors   = 0;

    uart_rx_assemble #(
        .CLK_DIV   (c_clk_div),
        .SYNC_WORD (c_sync),
        .IDLE_W    (c_idle_w)
    ) dut (
        .i_clk         (r_clk),
        .i_rst         (r_rst),
        .i_uart_rxd    (r_rxd),
        .i_fifo_full   (r_fifo_full),
        .o_data        (w_data),
        .o_fifo_wr_en  (w_wr_en),
        .o_locked      (w_locked),
        .o_line_active (w_line_active),
        .o_overflow    (w_overflow)
    );

    always #5 r_clk = ~r_clk;

    always @(posedge r_clk) r_cyc <= r_cyc + 1;

    always @(negedge r_clk) begin
        if (w_wr_en === 1'b1) r_wr_count <= r_wr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns during the clock cycle whose preceding rising edge has count c.
    task automatic wait_cyc(input int c);
        while (r_cyc < c) @(negedge r_clk);
    endtask

    task automatic check_write(input string tag, input int c, input logic [31:0] d);
        wait_cyc(c - 1);
        check({tag, "_pre"}, w_wr_en, 1'b0);
        wait_cyc(c);
        check({tag, "_we"}, w_wr_en, 1'b1);
        check({tag, "_data"}, w_data, d);
        wait_cyc(c + 1);
        check({tag, "_post"}, w_wr_en, 1'b0);
    endtask

    // Caller is 1 ns after a rising edge; returns 1 ns after edge S+512.
    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) begin
            r_rxd = w[i];
`ifdef UART_RX_MAJORITY_EN
            repeat (8) @(posedge r_clk);
            #1 r_rxd = ~w[i];
            @(posedge r_clk);
            #1 r_rxd = w[i];
            repeat (7) @(posedge r_clk);
            #1;
`else
            repeat (16) @(posedge r_clk);
            #1;
`endif
        end
    endtask

    initial begin
        int s;
        int wc;

        // Reset with the line idle
        #1 r_rst = 1'b1;
        repeat (3) @(posedge r_clk);
        #1;
        check("rst_data", w_data, 32'h0);
        check("rst_we", w_wr_en, 1'b0);
        check("rst_locked", w_locked, 1'b0);
        check("rst_active", w_line_active, 1'b0);
        check("rst_ovf", w_overflow, 1'b0);
        @(posedge r_clk);
        #1 r_rst = 1'b0;
        repeat (2) @(posedge r_clk);
        #1;
        check("idle_hold", w_line_active, 1'b0);

        // One transition: activity visible after the third edge
        r_rxd = 1'b0;
        repeat (2) @(posedge r_clk);
        #1;
        check("act_early", w_line_active, 1'b0);
        repeat (2) @(posedge r_clk);
        #1;
        check("act_rise", w_line_active, 1'b1);
        r_rxd = 1'b1;
        repeat (40) @(posedge r_clk);
        #1;

        // Sync followed by two data words
        s  = r_cyc;
        wc = r_wr_count;
        fork
            begin
                send_word(c_sync);
                send_word(32'h1234_5678);
                send_word(32'hDEAD_BEEF);
            end
            begin
                wait_cyc(s + c_lat - 1);
                check("lock_pre", w_locked, 1'b0);
                wait_cyc(s + c_lat);
                check("lock_rise", w_locked, 1'b1);
                check("sync_nowr", w_wr_en, 1'b0);
                check_write("w1", s + 512 + c_lat, 32'h1234_5678);
                check_write("w2", s + 1024 + c_lat, 32'hDEAD_BEEF);
            end
        join
        check("two_writes", r_wr_count - wc, 2);
        check("still_locked", w_locked, 1'b1);

        // Line held high until the idle counter saturates
        r_rxd = 1'b1;
        repeat (1100) @(posedge r_clk);
        #1;
        check("idle_inactive", w_line_active, 1'b0);
        check("idle_unlock", w_locked, 1'b0);

        // Relock after idle
        s = r_cyc;
        fork
            begin
                send_word(c_sync);
                send_word(32'h0F0F_3C3C);
            end
            check_write("relock", s + 512 + c_lat, 32'h0F0F_3C3C);
        join
        check("relock_locked", w_locked, 1'b1);

        // Asynchronous reset in the middle of a word
        send_word(c_sync);
        repeat (5) @(posedge r_clk);
        #3 r_rst = 1'b1;
        #1;
        check("arst_locked", w_locked, 1'b0);
        check("arst_active", w_line_active, 1'b0);
        check("arst_data", w_data, 32'h0);
        check("arst_we", w_wr_en, 1'b0);
        r_rxd = 1'b1;
        @(posedge r_clk);
        #1 r_rst = 1'b0;
        repeat (40) @(posedge r_clk);
        #1;

        // Data without a preceding sync word
        wc = r_wr_count;
        send_word(32'h1234_5678);
        r_rxd = 1'b1;
        repeat (600) @(posedge r_clk);
        #1;
        check("nosync_writes", r_wr_count - wc, 0);
        check("nosync_locked", w_locked, 1'b0);

        // Overflow: first word completes with the FIFO full
        r_fifo_full = 1'b1;
        s = r_cyc;
        fork
            begin
                send_word(c_sync);
                send_word(32'hCAFE_F00D);
                r_fifo_full = 1'b0;
                send_word(32'h1357_9BDF);
            end
            begin
                wait_cyc(s + 512 + c_lat - 1);
                check("ovf_pre", w_overflow, 1'b0);
                wait_cyc(s + 512 + c_lat);
                check("ovf_nowr", w_wr_en, 1'b0);
                check("ovf_set", w_overflow, 1'b1);
                check_write("ovf_next", s + 1024 + c_lat, 32'h1357_9BDF);
                check("ovf_sticky", w_overflow, 1'b1);
            end
        join

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
